// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory controller: geometry,
// word width and the controller state encoding.
package imem_pkg;

    localparam int ADDR_W    = 12;
    localparam int MEM_BYTES = 4096;
    localparam int WORD_W    = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        RESP  = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Builds a 32-bit little-endian instruction word one byte lane at a time.
// The word is held until the next fetch writes new lanes over it.
module imem_word_assembler
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        idx,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word
);

    // Capture the read byte into the lane selected by idx while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= {WORD_W{1'b0}};
        end else if (en) begin
            case (idx)
                2'd0:    word[7:0]   <= byte_in;
                2'd1:    word[15:8]  <= byte_in;
                2'd2:    word[23:16] <= byte_in;
                2'd3:    word[31:24] <= byte_in;
                default: word        <= word;
            endcase
        end else begin
            word <= word;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory controller: serves 32-bit fetches from a single-port
// byte RAM (four byte reads per word) and loads a program image byte by
// byte from a streaming loader, stalling the core while loading.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W    = imem_pkg::ADDR_W,
    parameter int MEM_BYTES = imem_pkg::MEM_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    output logic              fetch_err,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_done,
    output logic              ld_ovf,
    output logic [ADDR_W:0]   ld_count,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    state_t            state_r;
    state_t            state_n;
    logic              pend_r;
    logic              pend_n;
    logic [1:0]        idx_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W:0]   cnt_r;
    logic              ovf_r;
    logic              fvalid_r;
    logic              ferr_r;
    logic              done_r;
    logic              hold_r;
    logic              ready_r;
    logic              accept_s;
    logic              at_end_s;
    logic              err_s;
    logic              enter_load_s;
    logic              enter_fetch_s;
    logic              asm_en_s;

    assign accept_s      = (state_r == LOAD) && ready_r && ld_valid;
    assign at_end_s      = (ptr_r == ADDR_W'(MEM_BYTES - 1));
    assign enter_load_s  = (state_r == IDLE) && (state_n == LOAD);
    assign enter_fetch_s = (state_r == IDLE) && (state_n == FETCH);
    assign asm_en_s      = (state_r == FETCH);

    assign fetch_valid = fvalid_r;
    assign fetch_err   = ferr_r;
    assign ld_done     = done_r;
    assign ld_ready    = ready_r;
    assign cpu_hold    = hold_r;
    assign ld_ovf      = ovf_r;
    assign ld_count    = cnt_r;

    // Next-state selection; a pending load wins over a fetch in IDLE
    always_comb begin
        state_n = state_r;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_r || ld_start) begin
                    state_n = LOAD;
                end else if (fetch_req && (fetch_addr[1:0] == 2'b00)) begin
                    state_n = FETCH;
                end else if (fetch_req) begin
                    state_n = IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            FETCH: begin
                if (idx_r == 2'd3) begin
                    state_n = RESP;
                end else begin
                    state_n = FETCH;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            LOAD: begin
                if (accept_s && (ld_last || at_end_s)) begin
                    state_n = DONE;
                end else begin
                    state_n = LOAD;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pending-load flag: armed by ld_start outside LOAD, consumed on LOAD entry
    always_comb begin
        pend_n = pend_r;
        if (enter_load_s) begin
            pend_n = 1'b0;
        end else if (ld_start && (state_r != LOAD)) begin
            pend_n = 1'b1;
        end else begin
            pend_n = pend_r;
        end
    end

    // RAM port: byte reads during FETCH, byte writes only on an accepted load beat
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        case (state_r)
            FETCH: begin
                mem_addr = base_r + {{(ADDR_W-2){1'b0}}, idx_r};
            end
            LOAD: begin
                mem_addr = ptr_r;
                if (accept_s) begin
                    mem_wdata = ld_byte;
                    mem_we    = 1'b1;
                end else begin
                    mem_wdata = 8'h00;
                    mem_we    = 1'b0;
                end
            end
            default: begin
                mem_addr = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State register and pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            pend_r  <= pend_n;
        end
    end

    // Registered status outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fvalid_r <= 1'b0;
            ferr_r   <= 1'b0;
            done_r   <= 1'b0;
            hold_r   <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            fvalid_r <= (state_n == RESP);
            ferr_r   <= err_s;
            done_r   <= (state_n == DONE);
            hold_r   <= (state_n == LOAD) || (state_n == DONE);
            ready_r  <= (state_n == LOAD);
        end
    end

    // Fetch byte index and word base address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= 2'd0;
            base_r <= {ADDR_W{1'b0}};
        end else if (enter_fetch_s) begin
            idx_r  <= 2'd0;
            base_r <= fetch_addr;
        end else if (state_r == FETCH) begin
            idx_r  <= idx_r + 2'd1;
        end else begin
            idx_r  <= idx_r;
        end
    end

    // Load pointer, byte count and overflow flag; the pointer saturates at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {ADDR_W{1'b0}};
            cnt_r <= {(ADDR_W+1){1'b0}};
            ovf_r <= 1'b0;
        end else if (enter_load_s) begin
            ptr_r <= {ADDR_W{1'b0}};
            cnt_r <= {(ADDR_W+1){1'b0}};
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + {{ADDR_W{1'b0}}, 1'b1};
            if (at_end_s) begin
                ptr_r <= ptr_r;
                ovf_r <= ovf_r | ~ld_last;
            end else begin
                ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                ovf_r <= ovf_r;
            end
        end else begin
            ptr_r <= ptr_r;
            cnt_r <= cnt_r;
            ovf_r <= ovf_r;
        end
    end

    imem_word_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (asm_en_s),
        .idx     (idx_r),
        .byte_in (mem_rdata),
        .word    (fetch_data)
    );

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed self-checking bench for imem_ctrl with a behavioural byte RAM.
module tb_imem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [11:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_err;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_done;
    logic        ld_ovf;
    logic [12:0] ld_count;
    logic        cpu_hold;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:4095];
    int          we_cnt;
    int          a0_cnt;
    int          pass_cnt;
    int          total_cnt;

    imem_ctrl #(.ADDR_W(12), .MEM_BYTES(4096)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_err   (fetch_err),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .ld_done     (ld_done),
        .ld_ovf      (ld_ovf),
        .ld_count    (ld_count),
        .cpu_hold    (cpu_hold),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with write monitors
    assign mem_rdata = mem[mem_addr];
    initial begin
        we_cnt = 0;
        a0_cnt = 0;
    end
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt = we_cnt + 1;
            if (mem_addr == 12'd0) a0_cnt = a0_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++; if (cpu_hold !== 1'b0) $display("FAIL rst_cpu_hold got %0b exp 0", cpu_hold); else pass_cnt++;
        total_cnt++; if (ld_ready !== 1'b0) $display("FAIL rst_ld_ready got %0b exp 0", ld_ready); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %0b exp 0", mem_we); else pass_cnt++;
        total_cnt++; if (mem_addr !== 12'h000) $display("FAIL rst_mem_addr got %h exp 000", mem_addr); else pass_cnt++;
        total_cnt++; if (fetch_data !== 32'h0) $display("FAIL rst_fetch_data got %h exp 0", fetch_data); else pass_cnt++;
        total_cnt++; if (ld_count !== 13'd0 || ld_ovf !== 1'b0) $display("FAIL rst_ld_state got cnt=%0d ovf=%0b exp 0/0", ld_count, ld_ovf); else pass_cnt++;
        total_cnt++; if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || ld_done !== 1'b0) $display("FAIL rst_pulses got v=%0b e=%0b d=%0b exp 0", fetch_valid, fetch_err, ld_done); else pass_cnt++;
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_basic();
        logic [7:0] prog [0:3];
        prog[0] = 8'h93; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h0F;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        total_cnt++; if (ld_ready !== 1'b1 || cpu_hold !== 1'b1) $display("FAIL load_enter got rdy=%0b hold=%0b exp 1/1", ld_ready, cpu_hold); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_byte  = prog[i];
            ld_last  = (i == 3);
            #1;
            total_cnt++; if (mem_we !== 1'b1 || mem_addr !== 12'(i)) $display("FAIL load_beat%0d got we=%0b addr=%h exp 1/%0d", i, mem_we, mem_addr, i); else pass_cnt++;
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        total_cnt++; if (ld_done !== 1'b1 || ld_ready !== 1'b0) $display("FAIL load_done got done=%0b rdy=%0b exp 1/0", ld_done, ld_ready); else pass_cnt++;
        total_cnt++; if (ld_count !== 13'd4 || ld_ovf !== 1'b0) $display("FAIL load_count got cnt=%0d ovf=%0b exp 4/0", ld_count, ld_ovf); else pass_cnt++;
        tick();
        total_cnt++; if (ld_done !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL load_exit got done=%0b hold=%0b exp 0/0", ld_done, cpu_hold); else pass_cnt++;
        total_cnt++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h0F000093) $display("FAIL load_mem got %h exp 0f000093", {mem[3], mem[2], mem[1], mem[0]}); else pass_cnt++;
    endtask

    task automatic test_fetch(input logic [11:0] addr, input logic [31:0] exp_word, input string name);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        tick();
        tick();
        tick();
        total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL %s_early got %0b exp 0", name, fetch_valid); else pass_cnt++;
        tick();
        total_cnt++; if (fetch_valid !== 1'b1 || fetch_err !== 1'b0) $display("FAIL %s_valid got v=%0b e=%0b exp 1/0", name, fetch_valid, fetch_err); else pass_cnt++;
        total_cnt++; if (fetch_data !== exp_word) $display("FAIL %s_data got %h exp %h", name, fetch_data, exp_word); else pass_cnt++;
        fetch_req = 1'b0;
        tick();
        total_cnt++; if (fetch_valid !== 1'b0 || fetch_data !== exp_word) $display("FAIL %s_hold got v=%0b d=%h exp 0/%h", name, fetch_valid, fetch_data, exp_word); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        int we0;
        logic seen_valid;
        we0 = we_cnt;
        seen_valid = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 12'h006;
        tick();
        fetch_req = 1'b0;
        total_cnt++; if (fetch_err !== 1'b1) $display("FAIL mis_err got %0b exp 1", fetch_err); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (fetch_valid) seen_valid = 1'b1;
            tick();
        end
        total_cnt++; if (fetch_err !== 1'b0) $display("FAIL mis_err_pulse got %0b exp 0", fetch_err); else pass_cnt++;
        total_cnt++; if (seen_valid !== 1'b0) $display("FAIL mis_no_valid got %0b exp 0", seen_valid); else pass_cnt++;
        total_cnt++; if (we_cnt !== we0) $display("FAIL mis_no_write got %0d exp %0d", we_cnt - we0, 0); else pass_cnt++;
    endtask

    task automatic test_load_during_fetch();
        fetch_req  = 1'b1;
        fetch_addr = 12'h000;
        tick();
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        tick();
        tick();
        total_cnt++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h0F000093) $display("FAIL ldf_fetch got v=%0b d=%h exp 1/0f000093", fetch_valid, fetch_data); else pass_cnt++;
        total_cnt++; if (cpu_hold !== 1'b0) $display("FAIL ldf_hold_resp got %0b exp 0", cpu_hold); else pass_cnt++;
        fetch_req = 1'b0;
        tick();
        tick();
        total_cnt++; if (cpu_hold !== 1'b1 || ld_ready !== 1'b1) $display("FAIL ldf_load got hold=%0b rdy=%0b exp 1/1", cpu_hold, ld_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_load();
        logic seen_done;
        seen_done = 1'b0;
        ld_valid = 1'b1;
        ld_byte  = 8'hAA;
        tick();
        ld_byte  = 8'hBB;
        tick();
        ld_valid = 1'b0;
        total_cnt++; if (ld_count !== 13'd2) $display("FAIL rml_count got %0d exp 2", ld_count); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (ld_ready !== 1'b0 || cpu_hold !== 1'b0 || ld_count !== 13'd0) $display("FAIL rml_abort got rdy=%0b hold=%0b cnt=%0d exp 0/0/0", ld_ready, cpu_hold, ld_count); else pass_cnt++;
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ld_done) seen_done = 1'b1;
        end
        total_cnt++; if (seen_done !== 1'b0 || cpu_hold !== 1'b0 || ld_ready !== 1'b0) $display("FAIL rml_idle got done=%0b hold=%0b rdy=%0b exp 0/0/0", seen_done, cpu_hold, ld_ready); else pass_cnt++;
        total_cnt++; if ({mem[2], mem[1], mem[0]} !== 24'h00BBAA) $display("FAIL rml_mem got %h exp 00bbaa", {mem[2], mem[1], mem[0]}); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int a00;
        logic early;
        logic [7:0] b;
        early = 1'b0;
        a00 = a0_cnt;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_last  = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            b = i[7:0];
            ld_byte  = b ^ 8'h5A;
            ld_start = (i == 100);
            tick();
            if (i < 4095 && ld_done) early = 1'b1;
        end
        ld_valid = 1'b0;
        ld_start = 1'b0;
        total_cnt++; if (early !== 1'b0) $display("FAIL ovf_early_done got %0b exp 0", early); else pass_cnt++;
        total_cnt++; if (ld_done !== 1'b1 || ld_ovf !== 1'b1) $display("FAIL ovf_done got done=%0b ovf=%0b exp 1/1", ld_done, ld_ovf); else pass_cnt++;
        total_cnt++; if (ld_count !== 13'd4096) $display("FAIL ovf_count got %0d exp 4096", ld_count); else pass_cnt++;
        total_cnt++; if (a0_cnt - a00 !== 1) $display("FAIL ovf_addr0_writes got %0d exp 1", a0_cnt - a00); else pass_cnt++;
        total_cnt++; if (mem[4095] !== 8'hA5 || mem[0] !== 8'h5A) $display("FAIL ovf_mem got %h/%h exp a5/5a", mem[4095], mem[0]); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (cpu_hold !== 1'b0 || ld_done !== 1'b0 || ld_ovf !== 1'b1) $display("FAIL ovf_after got hold=%0b done=%0b ovf=%0b exp 0/0/1", cpu_hold, ld_done, ld_ovf); else pass_cnt++;
    endtask

    task automatic test_ovf_clear();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        total_cnt++; if (ld_ovf !== 1'b0 || ld_count !== 13'd0) $display("FAIL ovfclr_enter got ovf=%0b cnt=%0d exp 0/0", ld_ovf, ld_count); else pass_cnt++;
        ld_valid = 1'b1;
        ld_byte  = 8'h13;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        total_cnt++; if (ld_done !== 1'b1 || ld_count !== 13'd1 || ld_ovf !== 1'b0) $display("FAIL ovfclr_done got done=%0b cnt=%0d ovf=%0b exp 1/1/0", ld_done, ld_count, ld_ovf); else pass_cnt++;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 12'h000;
        ld_start   = 1'b0;
        ld_valid   = 1'b0;
        ld_byte    = 8'h00;
        ld_last    = 1'b0;
        test_reset();
        test_load_basic();
        test_fetch(12'h000, 32'h0F000093, "fetch0");
        test_misaligned();
        test_load_during_fetch();
        test_reset_mid_load();
        test_overflow();
        test_fetch(12'h004, 32'h5D5C5F5E, "fetch4");
        test_ovf_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
